// File: rtl/countdown_timer8.sv
// -----------------------------------------------------------------------------
// countdown_timer8
//
// Purpose:
//   Synchronous loadable down-counter that is preset to a count and raises a
//   one-cycle terminal-count pulse once that many RUN clocks have elapsed.
//   It presents the same true/complement output pair as the free-running
//   up-counter, so it can sit at the same arithmetic-unit hookup points.
//
//   The state machine has three states:
//     IDLE - waiting for LOAD or START
//     RUN  - decrementing once per clock
//     HOLD - paused by STOP, resumed by START
//
//   Each edge is resolved in this priority order:
//     rst > load > stop > start > counting
//
// Build option:
//   TIMER_AUTORELOAD_EN - when defined and the last loaded value is non-zero,
//   the terminal edge reloads the counter from that value and stays in RUN.
//   This produces a periodic done pulse. When the macro is undefined, or the
//   last loaded value is zero, the terminal edge clears q and returns to IDLE.
//
// Ports:
//   clk   in   rising-edge clock for all state
//   rst   in   synchronous, active-high reset
//   load  in   preset request; q and the reload register take d
//   d     in   [WIDTH-1:0] preset value
//   start in   arm / resume counting
//   stop  in   pause counting
//   q     out  [WIDTH-1:0] current count (registered)
//   nq    out  [WIDTH-1:0] bitwise complement of q (registered alongside q)
//   busy  out  high while in RUN (registered)
//   done  out  one-cycle terminal-count pulse (registered)
// -----------------------------------------------------------------------------
module countdown_timer8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             busy,
  output logic             done
);

`ifdef TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] nq_r;
  logic [WIDTH-1:0] rld_r;
  logic             busy_r;
  logic             done_r;
  logic             reload_en_s;

  // Decide whether the terminal edge reloads the counter.
  // A zero reload value behaves exactly like the non-reloading build.
  assign reload_en_s = AUTORELOAD && (rld_r != ZERO);

  // Control FSM together with the count, complement, busy and done registers.
  // nq_r is written next to every q_r update, so nq is always ~q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      q_r     <= ZERO;
      nq_r    <= ONES;
      rld_r   <= ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (load) begin
      // LOAD wins over START/STOP and cancels any pending terminal pulse.
      state_r <= IDLE;
      q_r     <= d;
      nq_r    <= ~d;
      rld_r   <= d;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, HOLD: begin
          if (stop) begin
            // STOP outside RUN does nothing, and it also masks START.
            state_r <= state_r;
          end else if (start) begin
            if (q_r != ZERO) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
            end else begin
              // Starting from zero: report completion immediately.
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end

        RUN: begin
          if (stop) begin
            state_r <= HOLD;
            busy_r  <= 1'b0;
          end else if (q_r > ONE) begin
            q_r  <= q_r - ONE;
            nq_r <= ~(q_r - ONE);
          end else if (q_r == ONE) begin
            // Terminal edge: the count of 1 is consumed on this edge.
            done_r <= 1'b1;
            if (reload_en_s) begin
              q_r  <= rld_r;
              nq_r <= ~rld_r;
            end else begin
              q_r     <= ZERO;
              nq_r    <= ONES;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            // q_r is zero in RUN; this is unreachable in normal
            // operation. Park in IDLE rather than wrap the count.
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_r;
  assign nq   = nq_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_countdown_timer8.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer8
//
// Self-checking bench for countdown_timer8.
//
// Each step does the following:
//   1. Drive one set of inputs.
//   2. Push the outputs expected after the next rising edge onto a scoreboard.
//   3. After that edge, pop the entry and compare q, nq, busy and done.
//
// Short scenarios come from a vector table. Long countdowns and the
// reset-mid-run cases are written as hand-coded loops.
//
// Build option: TIMER_AUTORELOAD_EN (must match the RTL build).
// -----------------------------------------------------------------------------
module tb_countdown_timer8;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] d;
  logic       start;
  logic       stop;
  logic [7:0] q;
  logic [7:0] nq;
  logic       busy;
  logic       done;

  countdown_timer8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d     (d),
    .start (start),
    .stop  (stop),
    .q     (q),
    .nq    (nq),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       start;
    logic       stop;
    logic [7:0] d;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pulse;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build one table vector.
  function automatic vec_t v(input logic r, input logic l, input logic s,
                             input logic p, input logic [7:0] dv,
                             input logic [7:0] eq, input logic eb,
                             input logic ed, input string nm);
    vec_t t;
    t.rst = r; t.load = l; t.start = s; t.stop = p; t.d = dv;
    t.eq = eq; t.eb = eb; t.ed = ed; t.name = nm;
    return t;
  endfunction

  // q after a terminal edge: the reload value in the autoreload build, else 0.
  function automatic logic [7:0] tq(input logic [7:0] rld);
    return AR ? rld : 8'h00;
  endfunction

  // Apply one cycle of stimulus, then check the outputs after the edge.
  task automatic step(input logic r, input logic l, input logic s,
                      input logic p, input logic [7:0] dv,
                      input logic [7:0] eq, input logic eb, input logic ed,
                      input string nm);
    exp_t e;
    rst = r; load = l; start = s; stop = p; d = dv;
    e.q = eq; e.busy = eb; e.done = ed; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (q !== e.q || nq !== ~e.q || busy !== e.busy || done !== e.done) begin
      n_err++;
      $display("FAIL %s: got q=%h nq=%h busy=%b done=%b, expected q=%h nq=%h busy=%b done=%b",
               e.name, q, nq, busy, done, e.q, ~e.q, e.busy, e.done);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; d = 8'h00;

    // Reset, then a basic countdown from 5.
    tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "reset1"));
    tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "reset2"));
    tv.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, "rst_beats_load"));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0, "load5"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0, "idle5"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0, "start5"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, "dec4"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 1'b0, "dec3"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, "dec2"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, "dec1"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tq(8'h05), AR, 1'b1, "term5"));
`ifndef TIMER_AUTORELOAD_EN
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "stay0"));
`endif

    // Pause and resume from 10: three decrements, STOP, then START again.
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h0A, 8'h0A, 1'b0, 1'b0, "load10"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0A, 1'b1, 1'b0, "start10"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b1, 1'b0, "dec9"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, "dec8"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 1'b1, 1'b0, "dec7"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h07, 1'b0, 1'b0, "stop7"));
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, "hold7"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h07, 1'b0, 1'b0, "stop_in_hold"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 1'b1, 1'b0, "resume7"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 1'b1, 1'b0, "rdec6"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0, "rdec5"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, "rdec4"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 1'b0, "rdec3"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, "rdec2"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, "rdec1"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tq(8'h0A), AR, 1'b1, "term10"));

    // START+STOP together in RUN (STOP wins), then LOAD mid-run at q=3.
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, "load3"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b1, 1'b0, "start3"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0, "start_stop"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, "held3"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b1, 1'b0, "resume3"));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h20, 1'b0, 1'b0, "load_midrun"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, "idle20"));

    // Zero and minimum values.
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "load0"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "start_at0"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "after_start0"));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, "load1"));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, "start1"));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tq(8'h01), AR, 1'b1, "term1"));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 1'b0, 1'b0, "reload20"));

    for (int i = 0; i < tv.size(); i++)
      step(tv[i].rst, tv[i].load, tv[i].start, tv[i].stop, tv[i].d,
           tv[i].eq, tv[i].eb, tv[i].ed, tv[i].name);

    // Count 32 after the mid-run LOAD.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, "start32");
    for (int i = 1; i < 32; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'(32 - i), 1'b1, 1'b0, "run32");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tq(8'h20), AR, 1'b1, "term32");

    // Count 255: must not wrap after reaching the end.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, "loadFF");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, "startFF");
    for (int i = 1; i < 255; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'(255 - i), 1'b1, 1'b0, "runFF");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tq(8'hFF), AR, 1'b1, "termFF");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, AR ? 8'hFE : 8'h00, AR, 1'b0, "no_wrap");

    // Reset during RUN, including on the edge where done was due.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0, "load5b");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0, "start5b");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, "dec4b");
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "rst_midrun");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, "load2");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, "start2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, "dec1b");
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "rst_kills_done");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "start0_after_rst");

`ifdef TIMER_AUTORELOAD_EN
    // Periodic pulses: with a reload value of 4, done fires every 4 cycles.
    n_pulse = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0, 1'b0, "ar_load4");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, "ar_start4");
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
           (k % 4 == 0) ? 8'h04 : 8'(4 - (k % 4)), 1'b1, (k % 4 == 0), "ar_run");
      if (done === 1'b1) n_pulse++;
    end
    n_vec++;
    if (n_pulse != 5) begin
      n_err++;
      $display("FAIL ar_pulse_count: got %0d pulses, expected 5", n_pulse);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0, "ar_stop");
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, "ar_halted");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "ar_load0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "ar_start0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "ar_idle0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
